// File: rtl/irrigation_event_logger.sv
// Timestamped event logger for smart_irrigation: edge detection, pending flags,
// fixed-priority arbiter and a show-ahead FIFO drained through valid/ready.
module irrigation_event_logger #(
    parameter int NUM_USERS = 4,
    parameter int WIDTH     = 6,
    parameter int TS_WIDTH  = 16,
    parameter int DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_1hz,
    input  logic                          valve_on,
    input  logic [1:0]                    current_zone,
    input  logic [WIDTH-1:0]              usage_out,
    input  logic [NUM_USERS-1:0]          quota_exceeded,
    input  logic                          rain,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [TS_WIDTH+3+2+WIDTH-1:0] evt_data,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic [7:0]                    drop_count,
    output logic [TS_WIDTH-1:0]           seconds
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_WIDTH + 3 + 2 + WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        EV_OPEN   = 3'd0,
        EV_CLOSE  = 3'd1,
        EV_QUOTA  = 3'd2,
        EV_RSTART = 3'd3,
        EV_REND   = 3'd4
    } evt_type_e;

    logic                 hz_s1_q, hz_s1_d, hz_s2_q, hz_s2_d, hz_s3_q, hz_s3_d;
    logic [TS_WIDTH-1:0]  seconds_q, seconds_d;
    logic                 prev_valve_q, prev_valve_d, prev_rain_q, prev_rain_d;
    logic [NUM_USERS-1:0] prev_quota_q, prev_quota_d;
    logic [1:0]           open_zone_q, open_zone_d;
    logic [NUM_USERS-1:0] quota_pend_q, quota_pend_d;
    logic                 close_pend_q, close_pend_d, open_pend_q, open_pend_d;
    logic                 rend_pend_q, rend_pend_d, rstart_pend_q, rstart_pend_d;
    logic [7:0]           drop_q, drop_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [EW-1:0]        evt_data_q, evt_data_d;
    logic [EW-1:0]        mem_q [DEPTH];

    logic                 valve_rise, valve_fall, rain_rise, rain_fall;
    logic [NUM_USERS-1:0] quota_rise, quota_sel, quota_clr, quota_drop;
    logic                 close_clr, open_clr, rend_clr, rstart_clr;
    logic                 any_pend, push, pop;
    evt_type_e            win_type;
    logic [1:0]           win_zone;
    logic [EW-1:0]        wr_entry;
    logic [7:0]           n_drop;
    logic [8:0]           drop_sum;

    always_comb begin
        hz_s1_d = clk_1hz;
        hz_s2_d = hz_s1_q;
        hz_s3_d = hz_s2_q;
        seconds_d = seconds_q;
        if (hz_s2_q && !hz_s3_q) seconds_d = seconds_q + TS_WIDTH'(1);

        prev_valve_d = valve_on;
        prev_rain_d  = rain;
        prev_quota_d = quota_exceeded;
        valve_rise   = valve_on & ~prev_valve_q;
        valve_fall   = ~valve_on & prev_valve_q;
        rain_rise    = rain & ~prev_rain_q;
        rain_fall    = ~rain & prev_rain_q;
        quota_rise   = quota_exceeded & ~prev_quota_q;
        open_zone_d  = valve_rise ? current_zone : open_zone_q;

        pop      = (count_q != '0) && evt_ready;
        any_pend = (|quota_pend_q) | close_pend_q | open_pend_q | rend_pend_q | rstart_pend_q;
        push     = any_pend && ((count_q != FULL) || pop);

        win_type  = EV_OPEN;
        win_zone  = open_zone_q;
        quota_sel = '0;
        close_clr = 1'b0;
        open_clr  = 1'b0;
        rend_clr  = 1'b0;
        rstart_clr = 1'b0;
        if (|quota_pend_q) begin
            win_type = EV_QUOTA;
            // Descending scan so the lowest pending zone is the last to overwrite.
            for (int i = NUM_USERS - 1; i >= 0; i--) begin
                if (quota_pend_q[i]) begin
                    win_zone     = 2'(i);
                    quota_sel    = '0;
                    quota_sel[i] = 1'b1;
                end
            end
        end else if (close_pend_q) begin
            win_type  = EV_CLOSE;
            close_clr = push;
        end else if (open_pend_q) begin
            win_type = EV_OPEN;
            open_clr = push;
        end else if (rend_pend_q) begin
            win_type = EV_REND;
            win_zone = 2'd0;
            rend_clr = push;
        end else if (rstart_pend_q) begin
            win_type   = EV_RSTART;
            win_zone   = 2'd0;
            rstart_clr = push;
        end
        quota_clr = push ? quota_sel : '0;

        quota_pend_d  = (quota_pend_q & ~quota_clr) | quota_rise;
        close_pend_d  = (close_pend_q & ~close_clr) | valve_fall;
        open_pend_d   = (open_pend_q & ~open_clr) | valve_rise;
        rend_pend_d   = (rend_pend_q & ~rend_clr) | rain_fall;
        rstart_pend_d = (rstart_pend_q & ~rstart_clr) | rain_rise;

        // A flag cleared this cycle absorbs its new edge without a drop.
        quota_drop = quota_rise & quota_pend_q & ~quota_clr;
        n_drop = 8'(valve_fall & close_pend_q & ~close_clr)
               + 8'(valve_rise & open_pend_q & ~open_clr)
               + 8'(rain_fall & rend_pend_q & ~rend_clr)
               + 8'(rain_rise & rstart_pend_q & ~rstart_clr);
        for (int i = 0; i < NUM_USERS; i++) n_drop = n_drop + 8'(quota_drop[i]);
        drop_sum = {1'b0, drop_q} + {1'b0, n_drop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        wr_entry = {seconds_q, win_type, win_zone, usage_out};
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        // Head register: bypass the write when it lands on the next head slot.
        evt_data_d = evt_data_q;
        if (push && (wr_ptr_q == rd_ptr_d)) evt_data_d = wr_entry;
        else if (count_d != '0) evt_data_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        hz_s1_q      <= hz_s1_d;
        hz_s2_q      <= hz_s2_d;
        hz_s3_q      <= hz_s3_d;
        prev_valve_q <= prev_valve_d;
        prev_rain_q  <= prev_rain_d;
        prev_quota_q <= prev_quota_d;
        if (rst) begin
            seconds_q     <= '0;
            open_zone_q   <= '0;
            quota_pend_q  <= '0;
            close_pend_q  <= 1'b0;
            open_pend_q   <= 1'b0;
            rend_pend_q   <= 1'b0;
            rstart_pend_q <= 1'b0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            evt_data_q    <= '0;
        end else begin
            seconds_q     <= seconds_d;
            open_zone_q   <= open_zone_d;
            quota_pend_q  <= quota_pend_d;
            close_pend_q  <= close_pend_d;
            open_pend_q   <= open_pend_d;
            rend_pend_q   <= rend_pend_d;
            rstart_pend_q <= rstart_pend_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            evt_data_q    <= evt_data_d;
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_data   = evt_data_q;
    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign seconds    = seconds_q;
endmodule

// File: tb/tb_irrigation_event_logger.sv
// Scoreboard bench for irrigation_event_logger; a narrow timestamp keeps the
// seconds wrap reachable in a short run.
module tb_irrigation_event_logger;
    localparam int NU  = 4;
    localparam int W   = 6;
    localparam int TSW = 12;
    localparam int D   = 8;
    localparam int EW  = TSW + 5 + W;

    logic           clk = 1'b0, rst = 1'b1, clk_1hz = 1'b0;
    logic           valve_on = 1'b1, rain = 1'b1, evt_ready = 1'b1;
    logic [1:0]     current_zone = 2'd0;
    logic [W-1:0]   usage_out = 6'h15;
    logic [NU-1:0]  quota_exceeded = 4'b0010;
    logic           evt_valid;
    logic [EW-1:0]  evt_data;
    logic [3:0]     fifo_count;
    logic [7:0]     drop_count;
    logic [TSW-1:0] seconds;

    int          n_cmp = 0, n_bad = 0, n_pop = 0, p0 = 0;
    int unsigned sec_model = 0;
    logic [EW-1:0] sb [$];
    logic [EW-1:0] exp_e;

    irrigation_event_logger #(.NUM_USERS(NU), .WIDTH(W), .TS_WIDTH(TSW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .valve_on(valve_on),
        .current_zone(current_zone), .usage_out(usage_out),
        .quota_exceeded(quota_exceeded), .rain(rain), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_data(evt_data), .fifo_count(fifo_count),
        .drop_count(drop_count), .seconds(seconds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int unsigned ts, input int typ, input int zone);
        return {TSW'(ts), 3'(typ), 2'(zone), usage_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (sb.size() != 0 || evt_valid); i++) tick();
        chk("drain", sb.size(), 0);
    endtask

    task automatic hz_pulse();
        clk_1hz = 1'b1;
        repeat (4) tick();
        clk_1hz = 1'b0;
        repeat (4) tick();
        sec_model++;
    endtask

    // Handshake seen on the falling edge is what the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            n_pop++;
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                exp_e = sb.pop_front();
                chk("evt_data", evt_data, exp_e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with levels asserted; release must log nothing.
        repeat (3) tick();
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_seconds", seconds, 0);
        chk("rst_data", evt_data, 0);
        rst = 1'b0;
        repeat (50) tick();
        chk("rel_valid", evt_valid, 0);
        chk("rel_drop", drop_count, 0);
        chk("rel_count", fifo_count, 0);

        // Falling levels after release: CLOSE outranks RAIN_END.
        valve_on = 1'b0; rain = 1'b0; quota_exceeded = 4'b0000;
        sb.push_back(mk(sec_model, 1, 0));
        sb.push_back(mk(sec_model, 4, 0));
        wait_drain();

        // Open/close with three seconds in between; 2-cycle visibility.
        current_zone = 2'd2;
        valve_on = 1'b1;
        sb.push_back(mk(sec_model, 0, 2));
        tick();
        chk("lat_k", evt_valid, 0);
        tick();
        chk("lat_k1", evt_valid, 1);
        wait_drain();
        repeat (3) hz_pulse();
        chk("seconds3", seconds, sec_model[TSW-1:0]);
        valve_on = 1'b0;
        sb.push_back(mk(sec_model, 1, 2));
        wait_drain();

        // Simultaneous quota bits, close and rain start, ready held high.
        valve_on = 1'b1;
        sb.push_back(mk(sec_model, 0, 2));
        wait_drain();
        quota_exceeded = 4'b0101; valve_on = 1'b0; rain = 1'b1;
        sb.push_back(mk(sec_model, 2, 0));
        sb.push_back(mk(sec_model, 2, 2));
        sb.push_back(mk(sec_model, 1, 2));
        sb.push_back(mk(sec_model, 3, 0));
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_valid", evt_valid, 1);
            chk("b2b_count", fifo_count, 1);
        end
        tick();
        chk("b2b_empty", evt_valid, 0);
        quota_exceeded = 4'b0000;
        wait_drain();

        // Fill with ready low, then overflow into flags and drops.
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valve_on = ~valve_on;
            sb.push_back(mk(sec_model, valve_on ? 0 : 1, 2));
            repeat (2) tick();
        end
        chk("full_count", fifo_count, 8);
        repeat (2) begin
            valve_on = 1'b1; repeat (2) tick();
            valve_on = 1'b0; repeat (2) tick();
        end
        sb.push_back(mk(sec_model, 1, 2));
        sb.push_back(mk(sec_model, 0, 2));
        chk("ovf_count", fifo_count, 8);
        chk("ovf_drop", drop_count, 2);
        chk("ovf_data_hold", evt_data, mk(sec_model, 0, 2));
        p0 = n_pop;
        evt_ready = 1'b1;
        for (int i = 0; i < 100 && evt_valid; i++) tick();
        chk("ovf_pops", n_pop - p0, 10);
        chk("ovf_valid", evt_valid, 0);
        chk("ovf_sb", sb.size(), 0);

        // Saturate the drop counter; contents are flushed by the reset below.
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valve_on = ~valve_on;
            repeat (2) tick();
        end
        for (int i = 0; i < 300; i++) begin
            rain = ~rain;
            tick();
        end
        chk("sat_drop", drop_count, 255);
        chk("sat_count", fifo_count, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sec_model = 0;
        chk("sat_rst_drop", drop_count, 0);
        chk("sat_rst_count", fifo_count, 0);

        // Reset pulsed while draining five entries.
        for (int i = 0; i < 5; i++) begin
            valve_on = ~valve_on;
            sb.push_back(mk(sec_model, valve_on ? 0 : 1, 2));
            repeat (2) tick();
        end
        chk("five_count", fifo_count, 5);
        evt_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_seconds", seconds, 0);
        rst = 1'b0;
        chk("mid_rst_left", sb.size(), 3);
        sb.delete();
        valve_on = 1'b0;
        sb.push_back(mk(sec_model, 1, 0));
        wait_drain();

        // Seconds wrap: 2^TSW + 1 edges from zero.
        for (int i = 0; i < (1 << TSW) + 1; i++) begin
            clk_1hz = 1'b1; tick();
            clk_1hz = 1'b0; tick();
        end
        repeat (4) tick();
        sec_model = ((1 << TSW) + 1) % (1 << TSW);
        chk("wrap_seconds", seconds, sec_model[TSW-1:0]);
        valve_on = 1'b1;
        sb.push_back(mk(sec_model, 0, 2));
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irrigation_event_logger.md
# irrigation_event_logger

Downstream consumer of `smart_irrigation` outputs. It detects valve open/close, per-zone quota-exceeded and rain start/end transitions, and stamps each with a seconds counter derived from `clk_1hz`. Events are queued in a show-ahead FIFO that a host or UART bridge drains through a valid/ready handshake. Events are never silently lost: a repeat event that cannot be recorded is counted.

## Interface
- NUM_USERS, 4, zones; must equal the upstream block's value
- WIDTH, 6, usage width; must equal the upstream block's value
- TS_WIDTH, 16, seconds-timestamp width
- DEPTH, 8, FIFO entries; power of two, ≥2
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- clk_1hz  in  1  slow seconds clock, asynchronous to clk
- valve_on  in  1  from smart_irrigation
- current_zone  in  2  from smart_irrigation
- usage_out  in  WIDTH  from smart_irrigation
- quota_exceeded  in  NUM_USERS  from smart_irrigation
- rain  in  1  rain sensor level
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head entry
- evt_data  out  TS_WIDTH+3+2+WIDTH  {timestamp, type[2:0], zone[1:0], usage}
- fifo_count  out  clog2(DEPTH)+1  entries held
- drop_count  out  8  dropped-event counter, saturating
- seconds  out  TS_WIDTH  running timestamp

## Operation
- Timestamp:
  - clk_1hz passes through a 2-flop synchroniser, then a rising-edge detect.
  - `seconds` increments by 1 on each detected edge and wraps modulo 2^TS_WIDTH.
- Edge detect: `prev_*` registers hold valve_on, rain and quota_exceeded.
  - During rst, each `prev_*` register loads its live input, not 0. Levels already asserted at reset release generate no events.
- Event types:
  - 0 VALVE_OPEN: zone = current_zone at the edge. This zone is also latched into `open_zone`.
  - 1 VALVE_CLOSE: zone = `open_zone`.
  - 2 QUOTA_HIT: one per rising bit of quota_exceeded; zone = bit index.
  - 3 RAIN_START: zone = 0.
  - 4 RAIN_END: zone = 0.
- Pending flags: each detected edge sets its flag.
  - There is 1 flag each for types 0, 1, 3, 4, plus a NUM_USERS-bit quota pending mask.
  - If an edge arrives while its flag (or mask bit) is still set, drop_count increments, saturating at 255. The flag stays set.
- Arbiter: at most one FIFO write per cycle. Fixed priority:
  1. QUOTA_HIT, lowest zone index first
  2. VALVE_CLOSE
  3. VALVE_OPEN
  4. RAIN_END
  5. RAIN_START
- The winning flag clears on the cycle its entry is written.
- Entry content: usage field = usage_out and timestamp = `seconds`, both sampled in the write cycle.
- Write condition: a flag is pending AND (fifo_count < DEPTH OR a pop occurs this cycle).
  - When full with no pop, flags are held, not dropped.
- Pop: evt_valid && evt_ready. The head advances next cycle.
- Push and pop in the same cycle leave fifo_count unchanged.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- evt_data is the registered head entry. It is stable while evt_valid=1 and evt_ready=0.
- An edge and the clearing of the same flag in one cycle: the clear takes effect, the new edge sets the flag, and no drop is counted.

## Timing
- Reset values:
  - evt_valid=0, fifo_count=0, drop_count=0, seconds=0
  - evt_data=0, all pending flags 0, open_zone=0
- Event latency:
  - Input edge sampled at posedge k sets the flag.
  - The entry is written at posedge k+1 if it wins arbitration and there is space.
  - evt_valid=1 after posedge k+1, i.e. 2 cycles from input change to visibility.
- Timestamp latency: clk_1hz rising → `seconds` increments 3 clk cycles later (2 sync + 1 edge).
- Back-to-back: N simultaneous pending events drain in N consecutive cycles, given space.
- rst asserted mid-operation: FIFO contents, flags and counters are discarded at the next posedge. There are no partial writes.
- evt_ready may be held high continuously. Throughput is 1 entry per cycle.

## Test plan
- Reset held with valve_on=1, rain=1, quota_exceeded=4'b0010; release → no entries after 50 cycles; evt_valid=0, drop_count=0.
- current_zone=2, valve_on 0→1, later 1→0, with 3 clk_1hz edges in between → two entries:
  - type0 zone2 seconds=s0
  - type1 zone2 seconds=s0+3
  - evt_valid first high 2 cycles after the open edge.
- Same cycle: quota_exceeded 0000→0101, valve_on 1→0, rain 0→1, evt_ready=1 → entries in order:
  - QUOTA z0
  - QUOTA z2
  - CLOSE
  - RAIN_START
  - written on 4 consecutive cycles.
- evt_ready=0, 8 valve toggles (8 entries, full), then 2 more open/close pairs → fifo_count=8, 2 flags pending, drop_count=2. Raise evt_ready → pending CLOSE, then OPEN drain, then evt_valid falls after the 10th pop.
- Drive 65 537 clk_1hz rising edges → seconds=1 (wrap). Force 300 drops → drop_count=255.
- 5 entries queued, rst pulsed 1 cycle mid-drain → next cycle fifo_count=0, evt_valid=0, seconds=0; a subsequent valve edge logs normally.
